// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner for the execute stage: moves, single-cycle multiply family
// and a 32-iteration restoring divider, behind a valid/ready + busy interface.
module hilo_muldiv_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [12:0] hi_lo_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d;
    logic [6:0]  op_q, op_d;
    logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    logic        accept;
    logic [12:0] sel;
    logic        div_signed;
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic [32:0] trial;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign accept     = req_valid & req_ready & (|hi_lo_op) & ~flush;
    // Isolate the lowest set bit so malformed multi-hot ops resolve deterministically.
    assign sel        = hi_lo_op & (~hi_lo_op + 13'd1);
    assign div_signed = sel[4];

    // op_q holds sel[12:6]: [0]mult [1]multu [2]mul [3]madd [4]maddu [5]msub [6]msubu
    assign mul_signed = op_q[0] | op_q[2] | op_q[3] | op_q[5];
    assign mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
    assign mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
    assign prod       = mul_a * mul_b;

    assign trial = {rem_q, quo_q[31]} - {1'b0, b_q};

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        op_d        = op_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        dz_d        = dz_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel[0]) begin
                        hi_d = src_a;
                    end else if (sel[1]) begin
                        lo_d = src_a;
                    end else if (sel[2]) begin
                        res_valid_d = 1'b1;
                        res_data_d  = hi_q;
                    end else if (sel[3]) begin
                        res_valid_d = 1'b1;
                        res_data_d  = lo_q;
                    end else if (sel[4] | sel[5]) begin
                        // a_q keeps the raw dividend for the divide-by-zero HI result.
                        a_d     = src_a;
                        quo_d   = (div_signed & src_a[31]) ? -src_a : src_a;
                        b_d     = (div_signed & src_b[31]) ? -src_b : src_b;
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        negq_d  = div_signed & (src_a[31] ^ src_b[31]);
                        negr_d  = div_signed & src_a[31];
                        dz_d    = (src_b == 32'd0);
                        state_d = DIV;
                    end else begin
                        a_d     = src_a;
                        b_d     = src_b;
                        op_d    = sel[12:6];
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (op_q[0] | op_q[1]) begin
                    {hi_d, lo_d} = prod;
                end else if (op_q[3] | op_q[4]) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + prod;
                end else if (op_q[5] | op_q[6]) begin
                    {hi_d, lo_d} = {hi_q, lo_q} - prod;
                end else begin
                    res_valid_d = 1'b1;
                    res_data_d  = prod[31:0];
                end
                state_d = IDLE;
            end
            DIV: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = negq_q ? -quo_q : quo_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            hi_d        = hi_q;
            lo_d        = lo_q;
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            cnt_q       <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            quo_q       <= 32'd0;
            rem_q       <= 32'd0;
            op_q        <= 7'd0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            dz_q        <= dz_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] hi_lo_op = 13'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        res_valid;
    logic [31:0] res_data;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_muldiv_unit #(.DIV_ITERS(32)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .hi_lo_op(hi_lo_op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .res_valid(res_valid), .res_data(res_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_res = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
    endtask

    // idx: 0 mthi 1 mtlo 2 mfhi 3 mflo 4 div 5 divu 6 mult 7 multu 8 mul 9 madd 10 maddu 11 msub 12 msubu
    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [12:0] extra);
        logic [63:0] acc, p;
        int n;
        bit rdy_bad;
        check("req_ready_idle", req_ready, 1'b1);
        hi_lo_op  = (13'd1 << idx) | extra;
        src_a     = a;
        src_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        hi_lo_op  = 13'd0;
        case (idx)
            0, 1: begin
                if (idx == 0) m_hi = a; else m_lo = a;
                check("mt_busy", busy, 1'b0);
                check("mt_res_valid", res_valid, 1'b0);
            end
            2, 3: begin
                m_res = (idx == 2) ? m_hi : m_lo;
                check("mf_busy", busy, 1'b0);
                check("mf_res_valid", res_valid, 1'b1);
            end
            4, 5: begin
                n = 0;
                rdy_bad = 1'b0;
                while (busy && n < 100) begin
                    if (req_ready) rdy_bad = 1'b1;
                    n++;
                    tick();
                end
                check("div_busy_cycles", n, 33);
                check("div_ready_low", rdy_bad, 1'b0);
                check("div_res_valid", res_valid, 1'b0);
                model_div(idx == 4, a, b);
            end
            default: begin
                check("mul_busy", busy, 1'b1);
                check("mul_ready", req_ready, 1'b0);
                tick();
                p   = model_prod(idx == 6 || idx == 8 || idx == 9 || idx == 11, a, b);
                acc = {m_hi, m_lo};
                if (idx == 6 || idx == 7) {m_hi, m_lo} = p;
                else if (idx == 9 || idx == 10) {m_hi, m_lo} = acc + p;
                else if (idx == 11 || idx == 12) {m_hi, m_lo} = acc - p;
                else m_res = p[31:0];
                check("mul_res_valid", res_valid, idx == 8);
                check("mul_busy_done", busy, 1'b0);
            end
        endcase
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("res_data", res_data, m_res);
    endtask

    function automatic logic [31:0] pick_val(input bit allow_zero);
        case ($urandom_range(0, 5))
            0: return allow_zero ? 32'd0 : 32'd1;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [12:0] msk;
        logic [12:0] extra;
        int idx;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        resetn = 1'b1;
        tick();

        issue(0, 32'h1234_5678, 32'd0, 13'd0);
        issue(1, 32'h9ABC_DEF0, 32'd0, 13'd0);
        issue(2, 32'd0, 32'd0, 13'd0);
        check("plan_mfhi", res_data, 32'h1234_5678);
        issue(3, 32'd0, 32'd0, 13'd0);
        check("plan_mflo", res_data, 32'h9ABC_DEF0);
        tick();
        check("mf_pulse_single", res_valid, 1'b0);

        issue(6, 32'hFFFF_FFFF, 32'd2, 13'd0);
        check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(7, 32'hFFFF_FFFF, 32'd2, 13'd0);
        check("plan_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue(0, 32'd0, 32'd0, 13'd0);
        issue(1, 32'hFFFF_FFFF, 32'd0, 13'd0);
        issue(9, 32'd1, 32'd1, 13'd0);
        check("plan_madd", {hi, lo}, 64'h0000_0001_0000_0000);
        issue(12, 32'd1, 32'd2, 13'd0);
        check("plan_msubu", {hi, lo}, 64'h0000_0000_FFFF_FFFE);
        issue(8, 32'd7, 32'hFFFF_FFFD, 13'd0);
        check("plan_mul", res_data, 32'hFFFF_FFEB);

        issue(4, 32'hFFFF_FFF9, 32'd2, 13'd0);
        check("plan_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(5, 32'd100, 32'd7, 13'd0);
        check("plan_divu", {hi, lo}, {32'd2, 32'd14});
        issue(4, 32'h55, 32'd0, 13'd0);
        check("plan_div0", {hi, lo}, {32'h55, 32'hFFFF_FFFF});
        issue(4, 32'h8000_0000, 32'hFFFF_FFFF, 13'd0);
        check("plan_div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

        // Multi-hot op: lowest index (mthi) must win over mflo/mult.
        issue(0, 32'hCAFE_0001, 32'd3, 13'b0_0000_0100_1000);

        // Flush mid-division.
        hi_lo_op = 13'd1 << 4; src_a = 32'd1000; src_b = 32'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; hi_lo_op = 13'd0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_div_busy", busy, 1'b0);
        check("flush_div_hi", hi, m_hi);
        check("flush_div_lo", lo, m_lo);
        issue(2, 32'd0, 32'd0, 13'd0);

        // Flush in final MUL cycle.
        hi_lo_op = 13'd1 << 6; src_a = 32'd5; src_b = 32'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; hi_lo_op = 13'd0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_mul_busy", busy, 1'b0);
        check("flush_mul_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush in the accept cycle drops the request.
        hi_lo_op = 13'd1 << 2; req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; hi_lo_op = 13'd0; flush = 1'b0;
        check("flush_acc_res_valid", res_valid, 1'b0);
        hi_lo_op = 13'd1 << 0; src_a = 32'hDEAD_BEEF; req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; hi_lo_op = 13'd0; flush = 1'b0;
        check("flush_acc_hi", hi, m_hi);
        check("flush_acc_busy", busy, 1'b0);

        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 12);
            msk = 13'h1FFF << (idx + 1);
            extra = ($urandom_range(0, 3) == 0) ? (13'($urandom) & msk) : 13'd0;
            issue(idx, pick_val(1'b1), pick_val(($urandom_range(0, 3) == 0)), extra);
        end

        // Reset asserted mid-division clears state without waiting for a clock.
        issue(0, 32'h1111_2222, 32'd0, 13'd0);
        issue(1, 32'h3333_4444, 32'd0, 13'd0);
        hi_lo_op = 13'd1 << 5; src_a = 32'd77; src_b = 32'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; hi_lo_op = 13'd0;
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
        tick();
        resetn = 1'b1;
        tick();
        issue(3, 32'd0, 32'd0, 13'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
